// File: rtl/branch_predict_ctrl.sv
// Branch prediction / redirect controller: 2-bit counter table, IF->ID->EX
// shadow pipeline of predictions, EX resolution with flush, redirect and training.
module branch_predict_ctrl #(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic [31:0]      if_pc_i,
  input  logic             if_is_branch_i,
  input  logic [31:0]      if_target_i,
  input  logic             ex_taken_i,
  output logic [31:0]      next_pc_o,
  output logic             pred_taken_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispredict_cnt_o
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt_e;

  cnt_e             table_q [DEPTH];

  logic             id_valid_q;
  logic [IDX_W-1:0] id_idx_q;
  logic             id_pred_q;
  logic [31:0]      id_alt_q;

  logic             ex_valid_q;
  logic [IDX_W-1:0] ex_idx_q;
  logic             ex_pred_q;
  logic [31:0]      ex_alt_q;

  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] mispredict_cnt_q;

  logic [IDX_W-1:0] if_idx;
  logic [1:0]       if_cnt;
  logic [31:0]      if_seq_pc;
  logic             ex_resolve;

  function automatic cnt_e cnt_step(input cnt_e c, input logic taken);
    cnt_e n;
    n = c;
    unique case (c)
      CNT_SNT: n = taken ? CNT_WNT : CNT_SNT;
      CNT_WNT: n = taken ? CNT_WT  : CNT_SNT;
      CNT_WT:  n = taken ? CNT_ST  : CNT_WNT;
      CNT_ST:  n = taken ? CNT_ST  : CNT_WT;
      default: n = CNT_WNT;
    endcase
    return n;
  endfunction

  // Prediction, resolution and next-PC selection; pred/flush held low during reset
  always_comb begin
    if_idx       = if_pc_i[IDX_W+1:2];
    if_cnt       = table_q[if_idx];
    if_seq_pc    = if_pc_i + 32'd4;
    pred_taken_o = rst_i & if_is_branch_i & if_cnt[1];
    ex_resolve   = rst_i & ex_valid_q;
    flush_o      = ex_resolve & (ex_taken_i != ex_pred_q);
    if (flush_o)           next_pc_o = ex_alt_q;
    else if (stall_i)      next_pc_o = if_pc_i;
    else if (pred_taken_o) next_pc_o = if_target_i;
    else                   next_pc_o = if_seq_pc;
  end

  // Counter table: reset to weak-NT, trained once per resolved EX branch
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) table_q[i] <= CNT_WNT;
    end else if (ex_resolve) begin
      table_q[ex_idx_q] <= cnt_step(table_q[ex_idx_q], ex_taken_i);
    end
  end

  // Shadow pipeline: flush clears both slots, stall holds ID and bubbles EX
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      id_valid_q <= 1'b0;
      id_idx_q   <= '0;
      id_pred_q  <= 1'b0;
      id_alt_q   <= '0;
      ex_valid_q <= 1'b0;
      ex_idx_q   <= '0;
      ex_pred_q  <= 1'b0;
      ex_alt_q   <= '0;
    end else begin
      if (flush_o || stall_i) begin
        ex_valid_q <= 1'b0;
      end else begin
        ex_valid_q <= id_valid_q;
        ex_idx_q   <= id_idx_q;
        ex_pred_q  <= id_pred_q;
        ex_alt_q   <= id_alt_q;
      end
      if (flush_o) begin
        id_valid_q <= 1'b0;
      end else if (!stall_i) begin
        id_valid_q <= if_is_branch_i;
        id_idx_q   <= if_idx;
        id_pred_q  <= pred_taken_o;
        id_alt_q   <= pred_taken_o ? if_seq_pc : if_target_i;
      end
    end
  end

  // Performance counters, wrapping naturally
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (ex_resolve) begin
      branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      if (flush_o) mispredict_cnt_q <= mispredict_cnt_q + CNT_W'(1);
    end
  end

  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl with a per-cycle reference model.
module tb_branch_predict_ctrl;

  localparam int IDX_W = 4;
  localparam int CNT_W = 16;
  localparam int NENT  = 1 << IDX_W;
  localparam int CMASK = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_i = 1'b0;
  logic             stall_i = 1'b0;
  logic [31:0]      if_pc_i = '0;
  logic             if_is_branch_i = 1'b0;
  logic [31:0]      if_target_i = '0;
  logic             ex_taken_i = 1'b0;
  logic [31:0]      next_pc_o;
  logic             pred_taken_o;
  logic             flush_o;
  logic [CNT_W-1:0] branch_cnt_o;
  logic [CNT_W-1:0] mispredict_cnt_o;

  int checks = 0;
  int failures = 0;

  branch_predict_ctrl #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .stall_i          (stall_i),
    .if_pc_i          (if_pc_i),
    .if_is_branch_i   (if_is_branch_i),
    .if_target_i      (if_target_i),
    .ex_taken_i       (ex_taken_i),
    .next_pc_o        (next_pc_o),
    .pred_taken_o     (pred_taken_o),
    .flush_o          (flush_o),
    .branch_cnt_o     (branch_cnt_o),
    .mispredict_cnt_o (mispredict_cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model: counters as saturating integers 0..3, in-flight branches as records
  typedef struct {
    bit          v;
    int          idx;
    bit          pred;
    logic [31:0] alt;
  } rec_t;

  int   m_tbl [NENT];
  rec_t m_id = '{0, 0, 0, 32'h0};
  rec_t m_ex = '{0, 0, 0, 32'h0};
  int   m_bcnt = 0;
  int   m_mcnt = 0;

  bit          e_pred, e_flush;
  logic [31:0] e_next;

  initial for (int i = 0; i < NENT; i++) m_tbl[i] = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, compare on the falling edge, advance the model on the rising edge
  task automatic cyc(input bit r, input bit s, input logic [31:0] pc, input bit br,
                     input logic [31:0] tgt, input bit tk);
    int   idx;
    bit   res;
    rec_t nid;
    rec_t nex;
    rst_i = r; stall_i = s; if_pc_i = pc; if_is_branch_i = br;
    if_target_i = tgt; ex_taken_i = tk;
    idx = int'((pc >> 2) % NENT);
    @(negedge clk);
    res     = r && m_ex.v;
    e_pred  = r && br && (m_tbl[idx] >= 2);
    e_flush = res && (tk != m_ex.pred);
    if (e_flush)     e_next = m_ex.alt;
    else if (s)      e_next = pc;
    else if (e_pred) e_next = tgt;
    else             e_next = pc + 32'd4;
    chk("next_pc", next_pc_o, e_next);
    chk("pred_taken", {31'b0, pred_taken_o}, {31'b0, e_pred});
    chk("flush", {31'b0, flush_o}, {31'b0, e_flush});
    chk("branch_cnt", {16'b0, branch_cnt_o}, m_bcnt);
    chk("mispredict_cnt", {16'b0, mispredict_cnt_o}, m_mcnt);
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < NENT; i++) m_tbl[i] = 1;
      m_id.v = 0; m_ex.v = 0; m_bcnt = 0; m_mcnt = 0;
    end else begin
      if (res) begin
        m_bcnt = (m_bcnt + 1) & CMASK;
        if (e_flush) m_mcnt = (m_mcnt + 1) & CMASK;
        m_tbl[m_ex.idx] = tk ? ((m_tbl[m_ex.idx] < 3) ? m_tbl[m_ex.idx] + 1 : 3)
                             : ((m_tbl[m_ex.idx] > 0) ? m_tbl[m_ex.idx] - 1 : 0);
      end
      nex = m_ex;
      nid = m_id;
      if (e_flush || s) nex.v = 0;
      else              nex = m_id;
      if (e_flush) nid.v = 0;
      else if (!s) begin
        nid.v = br; nid.idx = idx; nid.pred = e_pred;
        nid.alt = e_pred ? pc + 32'd4 : tgt;
      end
      m_ex = nex;
      m_id = nid;
    end
    #1;
  endtask

  // A lone branch: fetch, one filler, then resolve with the given outcome
  task automatic run_branch(input logic [31:0] pc, input logic [31:0] tgt, input bit tk);
    cyc(1, 0, pc, 1, tgt, 0);
    cyc(1, 0, pc + 32'd4, 0, 32'h0, 0);
    cyc(1, 0, pc + 32'd8, 0, 32'h0, tk);
  endtask

  int b0, m0;

  initial begin
    // Reset
    cyc(0, 0, 32'h0, 0, 32'h0, 0);
    cyc(0, 0, 32'h0, 1, 32'h10, 0);
    for (int i = 0; i < NENT; i++) chk("reset_tbl", {30'b0, dut.table_q[i]}, m_tbl[i]);

    // Branch at 0x40 resolving taken twice
    cyc(1, 0, 32'h40, 1, 32'h100, 0);
    chk("t1_first_pred", {31'b0, e_pred}, 32'd0);
    cyc(1, 0, 32'h44, 0, 32'h0, 0);
    cyc(1, 0, 32'h48, 0, 32'h0, 1);
    chk("t1_flush", {31'b0, e_flush}, 32'd1);
    chk("t1_redirect", e_next, 32'h100);
    chk("t1_tbl_after1", m_tbl[0], 32'd2);
    cyc(1, 0, 32'h40, 1, 32'h100, 0);
    chk("t1_second_pred", {31'b0, e_pred}, 32'd1);
    chk("t1_second_next", e_next, 32'h100);
    cyc(1, 0, 32'h100, 0, 32'h0, 0);
    cyc(1, 0, 32'h104, 0, 32'h0, 1);
    chk("t1_no_flush", {31'b0, e_flush}, 32'd0);
    cyc(1, 0, 32'h108, 0, 32'h0, 0);
    chk("t1_tbl_after2", m_tbl[0], 32'd3);
    chk("t1_bcnt", m_bcnt, 32'd2);
    chk("t1_mcnt", m_mcnt, 32'd1);

    // Loop branch T,T,T,N x4 at 0x24 (index 9)
    m0 = m_mcnt;
    for (int it = 0; it < 4; it++)
      for (int k = 0; k < 4; k++) begin
        run_branch(32'h24, 32'h4, k != 3);
        if (it > 0 || k > 0) chk("t2_range", {31'b0, m_tbl[9] >= 2}, 32'd1);
      end
    chk("t2_mispredicts", m_mcnt - m0, 32'd5);
    chk("t2_final_tbl", m_tbl[9], 32'd2);

    // Stall for 3 cycles with a branch in ID (0x30, index 12)
    b0 = m_bcnt;
    cyc(1, 0, 32'h30, 1, 32'h300, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 32'h34, 0, 32'h0, 1);
      chk("t3_stall_next", e_next, 32'h34);
    end
    cyc(1, 0, 32'h34, 0, 32'h0, 1);
    cyc(1, 0, 32'h38, 0, 32'h0, 0);
    cyc(1, 0, 32'h3c, 0, 32'h0, 1);
    chk("t3_once", m_bcnt - b0, 32'd1);
    chk("t3_tbl", m_tbl[12], 32'd0);

    // Mispredict in EX while stall is asserted; the branch in ID is dropped
    b0 = m_bcnt; m0 = m_mcnt;
    cyc(1, 0, 32'h50, 1, 32'h200, 0);
    cyc(1, 0, 32'h54, 1, 32'h240, 0);
    cyc(1, 1, 32'h58, 0, 32'h0, 1);
    chk("t4_flush", {31'b0, e_flush}, 32'd1);
    chk("t4_redirect", e_next, 32'h200);
    cyc(1, 0, 32'h200, 0, 32'h0, 1);
    cyc(1, 0, 32'h204, 0, 32'h0, 1);
    cyc(1, 0, 32'h208, 0, 32'h0, 1);
    chk("t4_bcnt", m_bcnt - b0, 32'd1);
    chk("t4_mcnt", m_mcnt - m0, 32'd1);
    chk("t4_id_tbl", m_tbl[5], 32'd1);

    // Aliasing at index 0 (0x40 / 0x80 / 0xC0) and same-cycle read-before-write
    run_branch(32'h40, 32'h140, 0);
    chk("t5_pre", m_tbl[0], 32'd2);
    cyc(1, 0, 32'h40, 1, 32'h140, 0);
    cyc(1, 0, 32'h80, 1, 32'h180, 0);
    cyc(1, 0, 32'hC0, 1, 32'h1C0, 0);
    chk("t5_old_read", {31'b0, e_pred}, 32'd1);
    chk("t5_flush", {31'b0, e_flush}, 32'd1);
    chk("t5_redirect", e_next, 32'h44);
    cyc(1, 0, 32'h80, 1, 32'h180, 0);
    chk("t5_new_read", {31'b0, e_pred}, 32'd0);
    cyc(1, 0, 32'h84, 0, 32'h0, 0);
    cyc(1, 0, 32'h88, 0, 32'h0, 0);
    cyc(1, 0, 32'h8c, 0, 32'h0, 0);
    chk("t5_tbl", m_tbl[0], 32'd0);

    // Reset while a mispredicted branch sits in EX
    cyc(1, 0, 32'h60, 1, 32'h600, 0);
    cyc(1, 0, 32'h64, 0, 32'h0, 0);
    cyc(0, 0, 32'h68, 0, 32'h0, 1);
    chk("t6_no_flush_in_reset", {31'b0, e_flush}, 32'd0);
    cyc(1, 0, 32'h6c, 0, 32'h0, 1);
    chk("t6_no_flush_after", {31'b0, e_flush}, 32'd0);
    cyc(1, 0, 32'h70, 0, 32'h0, 1);
    chk("t6_bcnt", m_bcnt, 32'd0);
    chk("t6_mcnt", m_mcnt, 32'd0);
    for (int i = 0; i < NENT; i++) chk("t6_tbl", {30'b0, dut.table_q[i]}, m_tbl[i]);
    chk("t6_tbl0_model", m_tbl[0], 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
